udp_in_arb: RTL and testbench

Packet-atomic round-robin arbiter that shares the single byte-wide input FIFO write port of `udp_top` between `NUM_REQ` packet sources. Each source requests, waits for a one-hot grant, then streams one whole packet (sof..eof) through a zero-latency mux into the FIFO, honouring `in_full` back-pressure. The arbiter sits directly in front of `udp_top` and drives its `in_wr_en`/`in_din`/`in_wr_sof`/`in_wr_eof` pins.

---
 rtl/udp_in_arb.sv | 142 ++++++++++++++
 tb/tb_udp_in_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_in_arb.sv
// Packet-atomic round-robin arbiter feeding the udp_top input FIFO; zero-latency data mux, req_full mirrors in_full for the owner.
// Optional per-requester packet counters are enabled with `define UDP_ARB_STATS_EN.
module udp_in_arb #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_req,
  input  logic [NUM_REQ-1:0]       req_wr_en,
  input  logic [NUM_REQ*8-1:0]     req_din,
  input  logic [NUM_REQ-1:0]       req_wr_sof,
  input  logic [NUM_REQ-1:0]       req_wr_eof,
  output logic [NUM_REQ-1:0]       req_full,
  output logic                     in_wr_en,
  output logic [7:0]               in_din,
  output logic                     in_wr_sof,
  output logic                     in_wr_eof,
  input  logic                     in_full,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     err_proto,
  output logic [NUM_REQ*CNT_W-1:0] pkt_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      own_idx, nxt_idx, cand;
  logic               first_q, first_d;
  logic               found, acc;
  logic               wr_en_sel, sof_sel, eof_sel;
  logic [7:0]         din_sel;
  int                 scan;

  // Owner select; grant is one-hot, so at most one term contributes.
  always_comb begin
    own_idx   = '0;
    wr_en_sel = 1'b0;
    din_sel   = '0;
    sof_sel   = 1'b0;
    eof_sel   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        own_idx   = IW'(i);
        wr_en_sel = req_wr_en[i];
        din_sel   = req_din[i*8 +: 8];
        sof_sel   = req_wr_sof[i];
        eof_sel   = req_wr_eof[i];
      end
    end
  end

  // Round-robin scan starting just after the last packet's owner.
  always_comb begin
    nxt_idx = '0;
    found   = 1'b0;
    scan    = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = (int'(last_q) + k) % NUM_REQ;
      cand = IW'(scan);
      if (!found && req_req[cand]) begin
        found   = 1'b1;
        nxt_idx = cand;
      end
    end
  end

  assign acc       = (state_q == SEND) & wr_en_sel & ~in_full;
  assign req_full  = {NUM_REQ{in_full}} | ~grant;
  assign in_wr_en  = acc;
  assign in_din    = acc ? din_sel : 8'h00;
  assign in_wr_sof = acc & sof_sel;
  assign in_wr_eof = acc & eof_sel;
  // Flag framing errors but still forward the byte; the FIFO owner decides what to drop.
  assign err_proto = acc & (first_q ? ~sof_sel : sof_sel);

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    last_d  = last_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SEND;
          grant_d = NUM_REQ'(1) << nxt_idx;
          first_d = 1'b1;
        end
      end
      SEND: begin
        if (acc) begin
          first_d = 1'b0;
          if (eof_sel) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = own_idx;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

`ifdef UDP_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc && eof_sel && grant[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_in_arb.sv
// Scoreboarded bench for udp_in_arb: per-requester expected byte queues checked against the FIFO-side output.
module tb_udp_in_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_req, req_wr_en, req_wr_sof, req_wr_eof, req_full, grant;
  logic [15:0] req_din;
  logic        in_wr_en, in_wr_sof, in_wr_eof, in_full, err_proto;
  logic [7:0]  in_din;
  logic [31:0] pkt_cnt;

  udp_in_arb #(.NUM_REQ(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_req(req_req), .req_wr_en(req_wr_en), .req_din(req_din),
    .req_wr_sof(req_wr_sof), .req_wr_eof(req_wr_eof), .req_full(req_full),
    .in_wr_en(in_wr_en), .in_din(in_din), .in_wr_sof(in_wr_sof), .in_wr_eof(in_wr_eof),
    .in_full(in_full), .grant(grant), .err_proto(err_proto), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Entry layout: {err, sof, eof, data[7:0]}
  logic [10:0] exp_q [2][$];
  logic [1:0]  gseq[$];
  int          gapq[$];
  int          nbytes, run, maxrun, errcnt, full_cyc, idle_run;
  logic [1:0]  prev_g;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    nbytes = 0; run = 0; maxrun = 0; errcnt = 0; full_cyc = 0;
    gseq.delete(); gapq.delete();
  endtask

  always @(negedge clk) begin
    int own;
    logic [10:0] e;
    if (reset) begin
      prev_g = 2'b00;
      idle_run = 0;
    end else begin
      if (grant == 2'b00) idle_run++;
      else if (prev_g == 2'b00) begin
        gseq.push_back(grant);
        gapq.push_back(idle_run);
        idle_run = 0;
      end
      prev_g = grant;
      if (err_proto) errcnt++;
      if (in_full) begin
        full_cyc++;
        check_val("full_no_wr", in_wr_en, 0);
        check_val("full_bp", req_full, 2'b11);
      end
      if (in_wr_en) begin
        nbytes++;
        run++;
        if (run > maxrun) maxrun = run;
        check_val("wr_onehot", $onehot(grant), 1);
        own = grant[1] ? 1 : 0;
        check_val("sb_nonempty", exp_q[own].size() != 0, 1);
        if (exp_q[own].size() != 0) begin
          e = exp_q[own].pop_front();
          check_val("byte", {err_proto, in_wr_sof, in_wr_eof, in_din}, e);
        end
      end else begin
        run = 0;
      end
    end
  end

  // Pushes the packet to the scoreboard, requests, then streams it honouring req_full.
  // stop >= 0 leaves byte 'stop' driven and returns without completing the packet.
  task automatic send(input int r, input int len, input int sof_a, input int sof_b,
                      input int stop, input bit chk_lat);
    logic [10:0] pk[$];
    logic s, e, er;
    logic [7:0] d;
    int waited, w;
    bit acc;
    for (int i = 0; i < len; i++) begin
      d  = 8'($urandom);
      s  = (i == sof_a) || (i == sof_b);
      e  = (i == len - 1);
      er = (i == 0) ? !s : s;
      pk.push_back({er, s, e, d});
      exp_q[r].push_back({er, s, e, d});
    end
    req_req[r] = 1'b1;
    waited = 0;
    while (waited < 300) begin
      @(posedge clk); #1;
      waited++;
      if (grant[r]) break;
    end
    check_val("grant_seen", grant[r], 1);
    if (!grant[r]) return;
    if (chk_lat) check_val("req2grant", waited, 1);
    for (int i = 0; i < len; i++) begin
      req_wr_en[r]        = 1'b1;
      req_din[r*8 +: 8]   = pk[i][7:0];
      req_wr_sof[r]       = pk[i][9];
      req_wr_eof[r]       = pk[i][8];
      if (i == stop) return;
      acc = 1'b0;
      w = 0;
      while (!acc && w < 300) begin
        @(negedge clk);
        acc = !req_full[r];
        @(posedge clk); #1;
        w++;
      end
      if (!acc) begin
        check_val("byte_accept", acc, 1);
        break;
      end
    end
    req_wr_en[r] = 1'b0; req_din[r*8 +: 8] = 8'h00;
    req_wr_sof[r] = 1'b0; req_wr_eof[r] = 1'b0;
    req_req[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_cnt;
    reset = 1'b1; in_full = 1'b0;
    req_req = '0; req_wr_en = '0; req_din = '0; req_wr_sof = '0; req_wr_eof = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_grant", grant, 0);
    check_val("rst_wr_en", in_wr_en, 0);
    check_val("rst_din", {in_din, in_wr_sof, in_wr_eof}, 0);
    check_val("rst_err", err_proto, 0);
    check_val("rst_full", req_full, 2'b11);
    check_val("rst_cnt", pkt_cnt, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single 60-byte packet; requester 1 pokes stray bytes without a grant.
    clear_stats();
    req_wr_en[1] = 1'b1; req_din[15:8] = 8'hA5; req_wr_sof[1] = 1'b1; req_wr_eof[1] = 1'b1;
    send(0, 60, 0, -1, -1, 1);
    check_val("t1_grant_idle", grant, 0);
    req_wr_en[1] = 1'b0; req_din[15:8] = 8'h00; req_wr_sof[1] = 1'b0; req_wr_eof[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_val("t1_bytes", nbytes, 60);
    check_val("t1_run", maxrun, 60);
    check_val("t1_ngrant", gseq.size(), 1);
    if (gseq.size() > 0) check_val("t1_grant", gseq[0], 2'b01);

    // Both requesters, three packets each; requester 0 owned last, so 1 goes first.
    clear_stats();
    fork
      begin repeat (3) send(0, 10, 0, -1, -1, 0); end
      begin repeat (3) send(1, 10, 0, -1, -1, 0); end
    join
    repeat (2) @(posedge clk); #1;
    check_val("t2_bytes", nbytes, 60);
    check_val("t2_ngrant", gseq.size(), 6);
    for (int i = 0; i < gseq.size(); i++)
      check_val("t2_grant_seq", gseq[i], (i % 2 == 0) ? 2'b10 : 2'b01);
    for (int i = 1; i < gapq.size(); i++)
      check_val("t2_gap", gapq[i], 1);

    // in_full held for 5 cycles mid-packet.
    clear_stats();
    fork
      send(0, 30, 0, -1, -1, 0);
      begin
        repeat (8) @(posedge clk);
        #1 in_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_full = 1'b0;
      end
    join
    repeat (2) @(posedge clk); #1;
    check_val("t3_full_cyc", full_cyc, 5);
    check_val("t3_bytes", nbytes, 30);
    check_val("t3_q_empty", exp_q[0].size(), 0);

    // Framing errors: missing sof, extra sof at byte 3, then a legal single-byte packet.
    clear_stats();
    send(0, 5, -1, -1, -1, 0);
    send(0, 6, 0, 3, -1, 0);
    send(0, 1, 0, -1, -1, 0);
    repeat (2) @(posedge clk); #1;
    check_val("t4_err_pulses", errcnt, 2);
    check_val("t4_bytes", nbytes, 12);

    // Reset in the middle of a 40-byte packet.
    clear_stats();
    send(0, 40, 0, -1, 20, 0);
    #2 reset = 1'b1;
    #1;
    check_val("t5_grant", grant, 0);
    check_val("t5_wr_en", in_wr_en, 0);
    check_val("t5_full", req_full, 2'b11);
    check_val("t5_cnt", pkt_cnt, 0);
    check_val("t5_bytes", nbytes, 20);
    req_req = '0; req_wr_en = '0; req_din = '0; req_wr_sof = '0; req_wr_eof = '0;
    exp_q[0].delete(); exp_q[1].delete();
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();

    // After reset requester 0 wins even though it owned the last full packet; then count packets.
    fork
      begin repeat (3) send(0, 5, 0, -1, -1, 0); end
      begin repeat (5) send(1, 5, 0, -1, -1, 0); end
    join
    repeat (2) @(posedge clk); #1;
    check_val("t6_ngrant", gseq.size(), 8);
    if (gseq.size() > 0) check_val("t6_first", gseq[0], 2'b01);
`ifdef UDP_ARB_STATS_EN
    exp_cnt = {16'd5, 16'd3};
`else
    exp_cnt = 32'd0;
`endif
    check_val("t6_pkt_cnt", pkt_cnt, exp_cnt);
    check_val("t6_q0_empty", exp_q[0].size(), 0);
    check_val("t6_q1_empty", exp_q[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
